rr_pop_scheduler: RTL and testbench

- Parametrised successor to the fixed 4-channel round-robin block.
- Pops words from NUM_CH show-ahead input FIFOs in round-robin (RR) or weighted round-robin (WRR) order.
- Tags each popped word with its source channel id and stores it in an internal circular output buffer.
- The buffer is drained by a valid/ready consumer; the block sits between the per-port FIFOs and the downstream switch/memory stage.

---
 rtl/rr_pop_scheduler.sv | 110 +++++++++++
 tb/tb_rr_pop_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rr_pop_scheduler.sv
// rtl/rr_pop_scheduler.sv - RR/WRR pop scheduler feeding a tagged circular output buffer
module rr_pop_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int ID_W      = 2,
  parameter int DATA_W    = 5,
  parameter int BUF_DEPTH = 8,
  parameter int WEIGHT_W  = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            empty,
  input  logic [NUM_CH*DATA_W-1:0]     data_in,
  output logic [NUM_CH-1:0]            pop,
  input  logic                         mode,
  input  logic [NUM_CH*WEIGHT_W-1:0]   weights,
  output logic [DATA_W-1:0]            out_data,
  output logic [ID_W-1:0]              out_id,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(BUF_DEPTH):0]   buf_count
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;

  logic [ID_W-1:0]     ptr;
  logic [WEIGHT_W-1:0] credit;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [DATA_W-1:0]   buf_data [BUF_DEPTH];
  logic [ID_W-1:0]     buf_id   [BUF_DEPTH];

  logic            full;
  logic            burst;
  logic            owner_go;
  logic            found;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] g;
  logic            grant;
  logic            rd;
  int              idx;

  // Eligibility looks only at registered occupancy, so out_ready never reaches pop.
  always_comb begin
    full     = (buf_count == CW'(BUF_DEPTH));
    burst    = mode && (credit != '0);
    owner_go = burst && !empty[ptr];
    found    = 1'b0;
    sel      = ptr;
    idx      = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(ptr) + k) % NUM_CH;
      if (!found && !empty[idx]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
    grant = 1'b0;
    g     = ptr;
    if (!reset && !full) begin
      if (owner_go) begin
        grant = 1'b1;
        g     = ptr;
      end else if (found) begin
        grant = 1'b1;
        g     = sel;
      end
    end
    pop = grant ? (NUM_CH'(1) << g) : '0;
  end

  assign out_valid = (buf_count != '0);
  assign rd        = out_valid && out_ready;
  assign out_data  = out_valid ? buf_data[rd_ptr] : '0;
  assign out_id    = out_valid ? buf_id[rd_ptr]   : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= ID_W'(NUM_CH - 1);
      credit    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      buf_count <= '0;
    end else begin
      if (grant) wr_ptr <= wr_ptr + 1'b1;
      if (rd)    rd_ptr <= rd_ptr + 1'b1;
      buf_count <= buf_count + CW'(grant) - CW'(rd);
      if (!mode) begin
        credit <= '0;
        if (grant) ptr <= g;
      end else if (owner_go && !full) begin
        credit <= credit - 1'b1;
      end else if (grant) begin
        ptr    <= g;
        credit <= weights[int'(g)*WEIGHT_W +: WEIGHT_W];
      end else if (burst && !full) begin
        // Owner ran dry and nobody else is ready: fall back to idle.
        credit <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      buf_data[wr_ptr] <= data_in[int'(g)*DATA_W +: DATA_W];
      buf_id[wr_ptr]   <= g;
    end
  end

endmodule

// File: tb/tb_rr_pop_scheduler.sv
// tb/tb_rr_pop_scheduler.sv - directed bench for rr_pop_scheduler
module tb_rr_pop_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  empty;
  logic [19:0] data_in;
  logic [3:0]  pop;
  logic        mode;
  logic [11:0] weights;
  logic [4:0]  out_data;
  logic [1:0]  out_id;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  buf_count;

  int vectors    = 0;
  int miscompares = 0;
  int wrr_seq [14] = '{0, 0, 0, 0, 1, 1, 2, 2, 2, 3, 0, 0, 0, 0};

  rr_pop_scheduler #(
    .NUM_CH(4), .ID_W(2), .DATA_W(5), .BUF_DEPTH(8), .WEIGHT_W(3)
  ) dut (
    .clk(clk), .reset(reset), .empty(empty), .data_in(data_in), .pop(pop),
    .mode(mode), .weights(weights), .out_data(out_data), .out_id(out_id),
    .out_valid(out_valid), .out_ready(out_ready), .buf_count(buf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    empty     = 4'b0000;
    data_in   = {5'h04, 5'h03, 5'h02, 5'h01};
    mode      = 1'b0;
    weights   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    settle();
    check("rst_pop", 32'(pop), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_count", 32'(buf_count), 32'h0);
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_id", 32'(out_id), 32'h0);

    // RR fill, then drain in order
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      settle();
      check("rr_pop", 32'(pop), 32'(4'b0001 << (i % 4)));
      tick();
      check("rr_count", 32'(buf_count), 32'(i + 1));
    end
    settle();
    check("rr_full_pop", 32'(pop), 32'h0);
    empty     = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      settle();
      check("drain_id", 32'(out_id), 32'(i % 4));
      check("drain_data", 32'(out_data), 32'((i % 4) + 1));
      tick();
    end
    check("drain_count", 32'(buf_count), 32'h0);
    check("drain_valid", 32'(out_valid), 32'h0);

    // Sparse RR: ch0 and ch2 alternate, occupancy pinned at 1
    empty = 4'b1010;
    for (int k = 0; k < 6; k++) begin
      settle();
      check("sparse_pop", 32'(pop), (k % 2 == 0) ? 32'h1 : 32'h4);
      tick();
      check("sparse_count", 32'(buf_count), 32'h1);
      check("sparse_id", 32'(out_id), (k % 2 == 0) ? 32'h0 : 32'h2);
      check("sparse_data", 32'(out_data), (k % 2 == 0) ? 32'h1 : 32'h3);
    end
    empty = 4'b1111;
    tick();
    check("sparse_end_count", 32'(buf_count), 32'h0);

    // WRR weight bursts
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    mode    = 1'b1;
    weights = {3'd0, 3'd2, 3'd1, 3'd3};
    empty   = 4'b0000;
    for (int k = 0; k < 14; k++) begin
      settle();
      check("wrr_pop", 32'(pop), 32'(4'b0001 << wrr_seq[k]));
      tick();
    end
    check("wrr_count", 32'(buf_count), 32'h1);

    // WRR early exit: ch0 runs dry mid-burst, ch1 takes over in the same cycle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("exit_pop0", 32'(pop), 32'h1);
    tick();
    settle();
    check("exit_pop1", 32'(pop), 32'h1);
    tick();
    empty = 4'b0001;
    settle();
    check("exit_switch", 32'(pop), 32'h2);
    tick();
    settle();
    check("exit_ch1_burst", 32'(pop), 32'h2);
    tick();
    settle();
    check("exit_ch2", 32'(pop), 32'h4);

    // Full boundary: a read at full does not allow a same-cycle pop
    reset     = 1'b1;
    out_ready = 1'b0;
    mode      = 1'b0;
    empty     = 4'b0000;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("full_count", 32'(buf_count), 32'h8);
    out_ready = 1'b1;
    settle();
    check("full_read_pop", 32'(pop), 32'h0);
    tick();
    out_ready = 1'b0;
    check("full_after_read", 32'(buf_count), 32'h7);
    settle();
    check("full_refill_pop", 32'(pop), 32'h1);
    tick();
    settle();
    check("full_again_count", 32'(buf_count), 32'h8);
    check("full_again_pop", 32'(pop), 32'h0);

    // Reset in the middle of a ch2 burst
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    mode    = 1'b1;
    weights = {3'd0, 3'd3, 3'd0, 3'd0};
    empty   = 4'b1011;
    for (int i = 0; i < 3; i++) tick();
    settle();
    check("burst_count", 32'(buf_count), 32'h3);
    check("burst_pop", 32'(pop), 32'h4);
    empty = 4'b0000;
    reset = 1'b1;
    settle();
    check("burst_rst_pop", 32'(pop), 32'h0);
    tick();
    check("burst_rst_valid", 32'(out_valid), 32'h0);
    check("burst_rst_count", 32'(buf_count), 32'h0);
    reset = 1'b0;
    settle();
    check("post_rst_pop", 32'(pop), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
